// File: rtl/simt_stack_mw_if.sv
// simt_stack_mw_if: op/read/error bundle for the multi-warp SIMT stack (rd_hwm present when SIMT_STACK_HWM_EN is defined)
interface simt_stack_mw_if #(
  parameter int NUM_WARPS = 8,
  parameter int DEPTH = 16,
  parameter int PC_W = 32,
  parameter int MASK_W = 8
);
  localparam int WARP_W = $clog2(NUM_WARPS);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int E_W = 2 * PC_W + MASK_W;
  logic stall_i;
  logic op_valid;
  logic op_ready;
  logic [1:0] op_code;
  logic [WARP_W-1:0] op_warp;
  logic [PC_W-1:0] op_rpc;
  logic [PC_W-1:0] op_pc0;
  logic [MASK_W-1:0] op_mask0;
  logic [PC_W-1:0] op_pc1;
  logic [MASK_W-1:0] op_mask1;
  logic [WARP_W-1:0] rd_warp;
  logic [E_W-1:0] rd_tos;
  logic [E_W-1:0] rd_tos1;
  logic [CNT_W-1:0] rd_cnt;
  logic err_ovf;
  logic err_udf;
  logic [WARP_W-1:0] err_warp;
`ifdef SIMT_STACK_HWM_EN
  logic [CNT_W-1:0] rd_hwm;
  modport master (
    output stall_i, op_valid, op_code, op_warp, op_rpc, op_pc0, op_mask0, op_pc1, op_mask1, rd_warp,
    input op_ready, rd_tos, rd_tos1, rd_cnt, err_ovf, err_udf, err_warp, rd_hwm
  );
  modport slave (
    input stall_i, op_valid, op_code, op_warp, op_rpc, op_pc0, op_mask0, op_pc1, op_mask1, rd_warp,
    output op_ready, rd_tos, rd_tos1, rd_cnt, err_ovf, err_udf, err_warp, rd_hwm
  );
`else
  modport master (
    output stall_i, op_valid, op_code, op_warp, op_rpc, op_pc0, op_mask0, op_pc1, op_mask1, rd_warp,
    input op_ready, rd_tos, rd_tos1, rd_cnt, err_ovf, err_udf, err_warp
  );
  modport slave (
    input stall_i, op_valid, op_code, op_warp, op_rpc, op_pc0, op_mask0, op_pc1, op_mask1, rd_warp,
    output op_ready, rd_tos, rd_tos1, rd_cnt, err_ovf, err_udf, err_warp
  );
`endif
endinterface

// File: rtl/simt_stack_mw.sv
// simt_stack_mw: shared-array multi-warp SIMT reconvergence stack with registered TOS/TOS-1 read port (SIMT_STACK_HWM_EN adds rd_hwm)
module simt_stack_mw #(
  parameter int NUM_WARPS = 8,
  parameter int DEPTH = 16,
  parameter int PC_W = 32,
  parameter int MASK_W = 8
) (
  input logic clk,
  input logic reset,
  simt_stack_mw_if.slave bus
);
  localparam int WARP_W = $clog2(NUM_WARPS);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int E_W = 2 * PC_W + MASK_W;
  localparam int AW = $clog2(NUM_WARPS * DEPTH);
  logic [E_W-1:0] mem [NUM_WARPS*DEPTH];
  logic [CNT_W-1:0] cnt [NUM_WARPS];
  logic acc, m0, m1, both, ovf, udf, ok;
  logic [CNT_W-1:0] c, nc, rc;
  logic [AW-1:0] a_t, a_c, a_c1, ra0, ra1;
  function automatic logic [AW-1:0] ad(input logic [WARP_W-1:0] w, input logic [CNT_W-1:0] i);
    return AW'(int'(w) * DEPTH + int'(i));
  endfunction
  assign bus.op_ready = ~bus.stall_i;
  // decode the op, detect overflow/underflow and compute the warp's next occupancy
  always_comb begin
    acc = bus.op_valid & ~bus.stall_i;
    c = cnt[bus.op_warp];
    m0 = |bus.op_mask0;
    m1 = |bus.op_mask1;
    both = m0 & m1;
    ovf = acc & ((bus.op_code == 2'd0 && c == CNT_W'(DEPTH)) ||
                 (bus.op_code == 2'd1 && c != '0 && both && int'(c) + 2 > DEPTH));
    udf = acc & (bus.op_code == 2'd1 || bus.op_code == 2'd2) & (c == '0);
    ok = acc & ~ovf & ~udf;
    nc = bus.op_code == 2'd0 ? c + CNT_W'(1) :
         bus.op_code == 2'd1 ? (both ? c + CNT_W'(2) : c) :
         bus.op_code == 2'd2 ? c - CNT_W'(1) : '0;
    a_t = ad(bus.op_warp, c - CNT_W'(1));
    a_c = ad(bus.op_warp, c);
    a_c1 = ad(bus.op_warp, c + CNT_W'(1));
    rc = cnt[bus.rd_warp];
    ra0 = ad(bus.rd_warp, rc - CNT_W'(1));
    ra1 = ad(bus.rd_warp, rc - CNT_W'(2));
  end
  // entry storage: pushes/branch splits append, single-path branches redirect the TOS pc
  always_ff @(posedge clk)
    if (!reset && ok && bus.op_code == 2'd0)
      mem[a_c] <= {bus.op_rpc, bus.op_pc0, bus.op_mask0};
    else if (!reset && ok && bus.op_code == 2'd1 && both) begin
      mem[a_t][MASK_W +: PC_W] <= bus.op_rpc;
      mem[a_c] <= {bus.op_rpc, bus.op_pc1, bus.op_mask1};
      mem[a_c1] <= {bus.op_rpc, bus.op_pc0, bus.op_mask0};
    end else if (!reset && ok && bus.op_code == 2'd1 && (m0 | m1))
      mem[a_t][MASK_W +: PC_W] <= m0 ? bus.op_pc0 : bus.op_pc1;
  // occupancy, error reporting and the read port (read sees pre-op state)
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < NUM_WARPS; i++) cnt[i] <= '0;
      bus.rd_tos <= '0;
      bus.rd_tos1 <= '0;
      bus.rd_cnt <= '0;
      bus.err_ovf <= 1'b0;
      bus.err_udf <= 1'b0;
      bus.err_warp <= '0;
    end else begin
      if (ok) cnt[bus.op_warp] <= nc;
      bus.rd_cnt <= rc;
      bus.rd_tos <= rc != '0 ? mem[ra0] : '0;
      bus.rd_tos1 <= rc > CNT_W'(1) ? mem[ra1] : '0;
      bus.err_ovf <= ovf;
      bus.err_udf <= udf;
      if (ovf | udf) bus.err_warp <= bus.op_warp;
    end
`ifdef SIMT_STACK_HWM_EN
  logic [CNT_W-1:0] hwm [NUM_WARPS];
  // per-warp high-water mark of occupancy, zeroed by CLEAR
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < NUM_WARPS; i++) hwm[i] <= '0;
      bus.rd_hwm <= '0;
    end else begin
      if (ok) hwm[bus.op_warp] <= bus.op_code == 2'd3 ? '0 : (nc > hwm[bus.op_warp] ? nc : hwm[bus.op_warp]);
      bus.rd_hwm <= hwm[bus.rd_warp];
    end
`endif
endmodule
